// File: rtl/fxp_mult_pipe.sv
// fxp_mult_pipe: three-stage pipelined, multi-lane signed fixed-point multiplier
// with valid/ready flow control, saturation and sticky overflow status.
// Optional build macro FXP_MULT_ROUND_EN: round half away from zero on the
// magnitude before saturation; when undefined the result truncates toward zero.
module fxp_mult_pipe #(
    parameter int N     = 32,
    parameter int Q     = 12,
    parameter int LANES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*N-1:0]   in_a,
    input  logic [LANES*N-1:0]   in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*N-1:0]   out_p,
    output logic [LANES-1:0]     out_sat,
    output logic                 sat_sticky,
    input  logic                 sat_clr
);

    localparam logic [N-1:0]   C_ONE_N   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [2*N-1:0] C_ONE_2N  = {{(2*N-1){1'b0}}, 1'b1};
    localparam logic [2*N-1:0] C_LIM_NEG = C_ONE_2N << (N-1);
    localparam logic [2*N-1:0] C_LIM_POS = C_LIM_NEG - C_ONE_2N;
`ifdef FXP_MULT_ROUND_EN
    localparam logic [2*N-1:0] C_RND     = C_ONE_2N << (Q-1);
`else
    localparam logic [2*N-1:0] C_RND     = '0;
`endif

    // Stage valids
    logic r_v1, r_v2, r_v3;

    // Stage 1: magnitudes and sign
    logic [LANES-1:0][N-1:0]   r_mag_a;
    logic [LANES-1:0][N-1:0]   r_mag_b;
    logic [LANES-1:0]          r_sign1;

    // Stage 2: full-width magnitude product
    logic [LANES-1:0][2*N-1:0] r_m;
    logic [LANES-1:0]          r_sign2;

    // Stage 3: result
    logic [LANES*N-1:0]        r_p;
    logic [LANES-1:0]          r_sat;
    logic                      r_sticky;

    // Combinational helpers
    logic                      w_rdy1, w_rdy2, w_rdy3;
    logic [LANES-1:0][N-1:0]   w_mag_a;
    logic [LANES-1:0][N-1:0]   w_mag_b;
    logic [LANES-1:0]          w_sign;
    logic [LANES-1:0][2*N-1:0] w_prod;
    logic [LANES-1:0][2*N-1:0] w_sum;
    logic [LANES-1:0][2*N-1:0] w_r;
    logic [LANES-1:0][2*N-1:0] w_lim;
    logic [LANES-1:0][N-1:0]   w_mag_o;
    logic [LANES*N-1:0]        w_res;
    logic [LANES-1:0]          w_sat;

    // Ready chain: a stage can load when it is empty or its successor can load
    always_comb begin
        w_rdy3 = !r_v3 || out_ready;
        w_rdy2 = !r_v2 || w_rdy3;
        w_rdy1 = !r_v1 || w_rdy2;
    end

    assign in_ready   = w_rdy1;
    assign out_valid  = r_v3;
    assign out_p      = r_p;
    assign out_sat    = r_sat;
    assign sat_sticky = r_sticky;

    // Input decode: per-lane magnitude (most negative maps to 2^(N-1)) and sign
    always_comb begin
        w_mag_a = '0;
        w_mag_b = '0;
        w_sign  = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_mag_a[l] = in_a[l*N+N-1] ? (~in_a[l*N +: N] + C_ONE_N) : in_a[l*N +: N];
            w_mag_b[l] = in_b[l*N+N-1] ? (~in_b[l*N +: N] + C_ONE_N) : in_b[l*N +: N];
            w_sign[l]  = in_a[l*N+N-1] ^ in_b[l*N+N-1];
        end
    end

    // Unsigned magnitude product, zero-extended to 2N bits
    always_comb begin
        w_prod = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_prod[l] = {{N{1'b0}}, r_mag_a[l]} * {{N{1'b0}}, r_mag_b[l]};
        end
    end

    // Scale (optionally rounded), saturate against the sign-dependent limit, re-apply sign
    always_comb begin
        w_sum   = '0;
        w_r     = '0;
        w_lim   = '0;
        w_mag_o = '0;
        w_sat   = '0;
        w_res   = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_sum[l] = r_m[l] + C_RND;
            w_r[l]   = w_sum[l] >> Q;
            w_lim[l] = r_sign2[l] ? C_LIM_NEG : C_LIM_POS;
            if (w_r[l] > w_lim[l]) begin
                w_sat[l]   = 1'b1;
                w_mag_o[l] = w_lim[l][N-1:0];
            end else begin
                w_mag_o[l] = w_r[l][N-1:0];
            end
            w_res[l*N +: N] = r_sign2[l] ? (~w_mag_o[l] + C_ONE_N) : w_mag_o[l];
        end
    end

    // Stage 1 register: accept a beat on in_valid && in_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_sign1 <= '0;
        end else if (w_rdy1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_mag_a <= w_mag_a;
                r_mag_b <= w_mag_b;
                r_sign1 <= w_sign;
            end
        end
    end

    // Stage 2 register: product and carried sign
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            r_m     <= '0;
            r_sign2 <= '0;
        end else if (w_rdy2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_m     <= w_prod;
                r_sign2 <= r_sign1;
            end
        end
    end

    // Stage 3 register: result and per-lane flags, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3  <= 1'b0;
            r_p   <= '0;
            r_sat <= '0;
        end else if (w_rdy3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_p   <= w_res;
                r_sat <= w_sat;
            end
        end
    end

    // Sticky overflow: a saturating delivered beat wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (r_v3 && out_ready && (|r_sat)) begin
            r_sticky <= 1'b1;
        end else if (sat_clr) begin
            r_sticky <= 1'b0;
        end
    end

endmodule
